// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared state encoding and default RAM geometry for ram_arbiter.
package ram_arb_pkg;
    localparam int RAM_AW = 7;
    localparam int RAM_DW = 8;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;
endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// rr_arb2: two-requester grant picker, round-robin with RAM_ARB_RR_EN, fixed priority to port 0 otherwise.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);
`ifdef RAM_ARB_RR_EN
    // r_ptr is the port that wins a tie; it moves off whichever port was just granted
    logic r_ptr;
    always_ff @(posedge clk) begin
        if (rst) r_ptr <= 1'b0;
        else if (update && |gnt) r_ptr <= gnt[0];
    end
    always_comb gnt = (&req) ? (r_ptr ? 2'b10 : 2'b01) : req;
`else
    logic w_unused;
    assign w_unused = clk ^ rst ^ update;
    always_comb gnt = req[0] ? 2'b01 : req;
`endif
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: serializes two requesters onto one synchronous-read RAM port (IDLE/ACCESS/RESP).
// Round-robin arbitration when RAM_ARB_RR_EN is defined, fixed priority otherwise.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW = RAM_AW,
    parameter int DW = RAM_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          busy,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);
    state_t        r_state, w_next;
    logic [1:0]    w_gnt;
    logic          w_update, r_gnt, r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata, r_rdata0, r_rdata1;

    assign w_update = (r_state == ST_IDLE) && (req0 || req1);

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({req1, req0}),
        .update (w_update),
        .gnt    (w_gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = ST_IDLE;
        if (r_state == ST_IDLE && w_update) w_next = ST_ACCESS;
        else if (r_state == ST_ACCESS) w_next = ST_RESP;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_update) begin
            r_gnt   <= w_gnt[1];
            r_we    <= w_gnt[1] ? we1 : we0;
            r_addr  <= w_gnt[1] ? addr1 : addr0;
            r_wdata <= w_gnt[1] ? wdata1 : wdata0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else if (r_state == ST_RESP && !r_we) begin
            if (r_gnt) r_rdata1 <= ram_rdata;
            else r_rdata0 <= ram_rdata;
        end
    end

    // r_we keeps the op type through RESP; the RAM strobe is only live during ACCESS
    assign ram_we    = r_we && (r_state == ST_ACCESS) && !rst;
    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;
    assign busy      = r_state != ST_IDLE;
    assign ack0      = (r_state == ST_RESP) && !r_gnt;
    assign ack1      = (r_state == ST_RESP) && r_gnt;
    assign rdata0    = (ack0 && !r_we) ? ram_rdata : r_rdata0;
    assign rdata1    = (ack1 && !r_we) ? ram_rdata : r_rdata1;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed table-driven bench for ram_arbiter with a behavioural 128x8 sync-read RAM.
module tb_ram_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [6:0] addr0 = 0, addr1 = 0;
    logic [7:0] wdata0 = 0, wdata1 = 0;
    logic       ack0, ack1, busy, ram_we;
    logic [7:0] rdata0, rdata1, ram_wdata;
    logic [6:0] ram_addr;
    logic [7:0] ram_rdata = 8'h00;
    logic [7:0] mem [128] = '{default: 8'h00};
    logic [7:0] last_rd [2];
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit         p;
        bit         w;
        logic [6:0] a;
        logic [7:0] d;
        logic [7:0] rd;
    } vec_t;
    vec_t vecs [10];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    ram_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .busy(busy), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit p, input bit on, input bit w, input logic [6:0] a, input logic [7:0] d);
        if (p) begin req1 = on; we1 = w; addr1 = a; wdata1 = d; end
        else begin req0 = on; we0 = w; addr0 = a; wdata0 = d; end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
    endtask

    task automatic xact(input bit p, input bit w, input logic [6:0] a, input logic [7:0] d, input logic [7:0] exp_rd);
        int n = 0;
        int other = 0;
        bit got = 0;
        drive(p, 1'b1, w, a, d);
        while (!got && n < 10) begin
            cyc();
            n++;
            if (p ? ack0 : ack1) other++;
            if (p ? ack1 : ack0) got = 1;
        end
        drive(p, 1'b0, 1'b0, 7'd0, 8'd0);
        chk($sformatf("ack latency p%0d a%0d", p, a), got ? n : 99, 2);
        chk($sformatf("other ack p%0d a%0d", p, a), other, 0);
        if (!w) last_rd[p] = exp_rd;
        chk($sformatf("rdata p%0d a%0d", p, a), p ? rdata1 : rdata0, last_rd[p]);
        cyc();
        chk("busy after resp", busy, 0);
    endtask

    initial begin
        int k, both, a0_at, a1_at, cnt;
        logic [5:0] seq, exp_seq;
        vecs[0] = '{0, 1, 7'd10,  8'hAA, 8'h00};
        vecs[1] = '{0, 0, 7'd10,  8'h00, 8'hAA};
        vecs[2] = '{1, 1, 7'd5,   8'h12, 8'h00};
        vecs[3] = '{1, 0, 7'd5,   8'h00, 8'h12};
        vecs[4] = '{0, 1, 7'd0,   8'hFF, 8'h00};
        vecs[5] = '{1, 1, 7'd127, 8'h01, 8'h00};
        vecs[6] = '{0, 0, 7'd0,   8'h00, 8'hFF};
        vecs[7] = '{1, 0, 7'd127, 8'h00, 8'h01};
        vecs[8] = '{1, 0, 7'd10,  8'h00, 8'hAA};
        vecs[9] = '{0, 0, 7'd127, 8'h00, 8'h01};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset ctl", {ack0, ack1, busy, ram_we}, 0);
        chk("reset cmd", {ram_addr, ram_wdata}, 0);
        chk("reset rdata", {rdata0, rdata1}, 0);
        rst = 1'b0;
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;

        for (int i = 0; i < 10; i++) xact(vecs[i].p, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].rd);

        // simultaneous writes straight after reset
        do_reset();
        drive(0, 1, 1, 7'd20, 8'h55);
        drive(1, 1, 1, 7'd21, 8'h33);
        a0_at = 0; a1_at = 0; both = 0;
        for (int n = 1; n <= 12; n++) begin
            cyc();
            if (ack0 && ack1) both++;
            if (ack0 && a0_at == 0) begin a0_at = n; drive(0, 0, 0, 7'd0, 8'd0); end
            if (ack1 && a1_at == 0) begin a1_at = n; drive(1, 0, 0, 7'd0, 8'd0); end
        end
        chk("simul ack0 cycle", a0_at, 2);
        chk("simul ack1 cycle", a1_at, 5);
        chk("simul both acks", both, 0);
        xact(0, 0, 7'd20, 8'h00, 8'h55);
        xact(1, 0, 7'd21, 8'h00, 8'h33);

        // persistent contention: both ports keep reading
        drive(0, 1, 0, 7'd20, 8'h00);
        drive(1, 1, 0, 7'd21, 8'h00);
        k = 0; both = 0; seq = '0; cnt = 0;
        while (k < 6 && cnt < 40) begin
            cyc();
            cnt++;
            if (ack0 && ack1) both++;
            if (ack0) begin
                chk("contention rdata0", rdata0, 8'h55);
                k++;
            end else if (ack1) begin
                chk("contention rdata1", rdata1, 8'h33);
                seq[k] = 1'b1;
                k++;
            end
            if (k == 6) begin
                drive(0, 0, 0, 7'd0, 8'd0);
                drive(1, 0, 0, 7'd0, 8'd0);
            end
        end
`ifdef RAM_ARB_RR_EN
        exp_seq = 6'b101010;
`else
        exp_seq = 6'b000000;
`endif
        chk("contention acks", k, 6);
        chk("contention order", seq, exp_seq);
        chk("contention both acks", both, 0);
        drive(0, 0, 0, 7'd0, 8'd0);
        drive(1, 0, 0, 7'd0, 8'd0);
        cyc();
        chk("contention idle", busy, 0);

        // reset during a write's ACCESS cycle
        drive(1, 1, 1, 7'd5, 8'h77);
        cyc();
        chk("ram_we in access", ram_we, 1);
        rst = 1'b1;
        #1;
        chk("ram_we gated by rst", ram_we, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 0, 0, 7'd0, 8'd0);
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        chk("post-rst ctl", {ack0, ack1, busy, ram_we}, 0);
        chk("post-rst cmd", {ram_addr, ram_wdata}, 0);
        chk("post-rst rdata", {rdata0, rdata1}, 0);
        cnt = 0;
        for (int n = 0; n < 3; n++) begin
            cyc();
            if (ack1) cnt++;
        end
        chk("no ack1 after rst", cnt, 0);
        xact(1, 0, 7'd5, 8'h00, 8'h12);

        // req1 pulsed only while port 0 is in flight
        drive(0, 1, 0, 7'd0, 8'h00);
        cyc();
        drive(1, 1, 0, 7'd127, 8'h00);
        cyc();
        drive(1, 0, 0, 7'd0, 8'h00);
        chk("early drop ack0", ack0, 1);
        chk("early drop rdata0", rdata0, 8'hFF);
        drive(0, 0, 0, 7'd0, 8'h00);
        cyc();
        chk("early drop busy", busy, 0);
        cnt = 0; both = 0;
        for (int n = 0; n < 4; n++) begin
            cyc();
            if (ack1) cnt++;
            if (busy) both++;
        end
        chk("early drop no ack1", cnt, 0);
        chk("early drop stays idle", both, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
